// File: rtl/seg_pkg.sv
// Shared seven-segment constants: blank pattern and nibble-to-segment table.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seg_pkg;

  // Segments {a,b,c,d,e,f,g} at bits [6:0], active-low.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Packed table with entry k holding the pattern for nibble k (entry 0 is rightmost).
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage

// File: rtl/seg_decode.sv
// Nibble to active-low seven-segment decode; 10-15 show hex glyphs only with SEG_HEX_EN.
// Latency: purely combinational.
// Backpressure: none.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Table lookup; without hex support the letters are blanked.
  always_comb begin
`ifdef SEG_HEX_EN
    seg = SEG_LUT[nib];
`else
    seg = (nib > 4'd9) ? SEG_BLANK : SEG_LUT[nib];
`endif
  end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed seven-segment driver with frame-synchronous update (SEG_HEX_EN enables hex glyphs).
// Latency: anode/cathode/dp_n registered 1 cycle after cnt/idx; loads take effect at the next frame wrap.
// Backpressure: none; load is a fire-and-forget strobe, later loads before the wrap overwrite earlier ones.
module seg_display_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [6:0]              cathode,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    pending,
  output logic                    frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = ($clog2(NUM_DIGITS) < 1) ? 1 : $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pending_q, pending_d;
  logic [DW-1:0]         shadow_dig_q, shadow_dig_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            cathode_q, cathode_d;
  logic                  dp_n_q, dp_n_d;

  logic                  slot_end;
  logic                  wrap;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic [6:0]            cur_seg;

  // Slot/digit counters, frame wrap detection and the pending/shadow handoff.
  always_comb begin
    slot_end     = (cnt_q == CNT_LAST);
    wrap         = slot_end && (idx_q == IDX_LAST);
    cnt_d        = slot_end ? '0 : cnt_q + CW'(1);
    idx_d        = idx_q;
    frame_tick_d = wrap;
    pend_dig_d   = pend_dig_q;
    pend_dp_d    = pend_dp_q;
    pending_d    = pending_q;
    shadow_dig_d = shadow_dig_q;
    shadow_dp_d  = shadow_dp_q;

    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    if (wrap) begin
      // A load landing on the wrap goes straight to the display; otherwise
      // only a genuinely waiting buffer is promoted, so an older buffer never
      // overwrites a newer direct write.
      pending_d = 1'b0;
      if (load) begin
        shadow_dig_d = digits_in;
        shadow_dp_d  = dp_in;
      end else if (pending_q) begin
        shadow_dig_d = pend_dig_q;
        shadow_dp_d  = pend_dp_q;
      end
    end else if (load) begin
      pend_dig_d = digits_in;
      pend_dp_d  = dp_in;
      pending_d  = 1'b1;
    end
  end

  // Select the shadow nibble and decimal point of the digit currently scanned.
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_nib = shadow_dig_q[k*4 +: 4];
        cur_dp  = shadow_dp_q[k];
      end
    end
  end

  seg_decode u_dec (
    .nib (cur_nib),
    .seg (cur_seg)
  );

  // Next output values; anodes stay dark during slot cycle 0 to hide ghosting.
  always_comb begin
    anode_d = '1;
    if (cnt_q != '0) begin
      anode_d[idx_q] = 1'b0;
    end
    cathode_d = cur_seg;
    dp_n_d    = ~cur_dp;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pending_q    <= 1'b0;
      shadow_dig_q <= '0;
      shadow_dp_q  <= '0;
      frame_tick_q <= 1'b0;
      anode_q      <= '1;
      cathode_q    <= SEG_BLANK;
      dp_n_q       <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pending_q    <= pending_d;
      shadow_dig_q <= shadow_dig_d;
      shadow_dp_q  <= shadow_dp_d;
      frame_tick_q <= frame_tick_d;
      anode_q      <= anode_d;
      cathode_q    <= cathode_d;
      dp_n_q       <= dp_n_d;
    end
  end

  assign anode      = anode_q;
  assign cathode    = cathode_q;
  assign dp_n       = dp_n_q;
  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux with NUM_DIGITS=4, REFRESH_DIV=4 (16-cycle frame).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_seg_display_mux;

  logic        clk = 1'b0;
  logic        clk_run = 1'b1;
  logic        rst_n;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        load;
  logic [6:0]  cathode;
  logic        dp_n;
  logic [3:0]  anode;
  logic        pending;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  seg_display_mux #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .load       (load),
    .cathode    (cathode),
    .dp_n       (dp_n),
    .anode      (anode),
    .pending    (pending),
    .frame_tick (frame_tick)
  );

  // Gateable clock: stops low when clk_run is cleared.
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance until frame_tick is seen, bounded to a few frames.
  task automatic wait_tick(input string name);
    int cyc;
    cyc = 0;
    while (cyc < 40) begin
      step(1);
      cyc++;
      if (frame_tick === 1'b1) break;
    end
    n_checks++;
    if (frame_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_tick_timeout got=%b exp=1", name, frame_tick);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #3;
    n_checks++; if (anode !== 4'b1111) begin n_fail++; $display("FAIL rst_anode got=%b exp=1111", anode); end
    n_checks++; if (cathode !== 7'b1111111) begin n_fail++; $display("FAIL rst_cathode got=%b exp=1111111", cathode); end
    n_checks++; if (dp_n !== 1'b1) begin n_fail++; $display("FAIL rst_dp_n got=%b exp=1", dp_n); end
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL rst_pending got=%b exp=0", pending); end
    n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL rst_tick got=%b exp=0", frame_tick); end
    step(2);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(1);
    n_checks++; if (anode !== 4'b1111) begin n_fail++; $display("FAIL rel_slot0_anode got=%b exp=1111", anode); end
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL rel_pending got=%b exp=0", pending); end
    step(1);
    n_checks++; if (anode !== 4'b1110) begin n_fail++; $display("FAIL rel_slot1_anode got=%b exp=1110", anode); end
    n_checks++; if (cathode !== 7'b0000001) begin n_fail++; $display("FAIL rel_cathode got=%b exp=0000001", cathode); end
  endtask

  task automatic test_load_scan();
    digits_in = 16'h1234;
    dp_in     = 4'b0001;
    load      = 1'b1;
    step(1);
    load = 1'b0;
    n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL ld_pending_set got=%b exp=1", pending); end
    wait_tick("ld");
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL ld_pending_clr got=%b exp=0", pending); end
    step(1);
    n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL ld_tick_width got=%b exp=0", frame_tick); end
    n_checks++; if (anode !== 4'b1111) begin n_fail++; $display("FAIL ld_ghost_anode got=%b exp=1111", anode); end
    step(1);
    n_checks++; if (anode !== 4'b1110) begin n_fail++; $display("FAIL ld_d0_anode got=%b exp=1110", anode); end
    n_checks++; if (cathode !== 7'b1001100) begin n_fail++; $display("FAIL ld_d0_cathode got=%b exp=1001100", cathode); end
    n_checks++; if (dp_n !== 1'b0) begin n_fail++; $display("FAIL ld_d0_dp got=%b exp=0", dp_n); end
    step(4);
    n_checks++; if (anode !== 4'b1101) begin n_fail++; $display("FAIL ld_d1_anode got=%b exp=1101", anode); end
    n_checks++; if (cathode !== 7'b0000110) begin n_fail++; $display("FAIL ld_d1_cathode got=%b exp=0000110", cathode); end
    n_checks++; if (dp_n !== 1'b1) begin n_fail++; $display("FAIL ld_d1_dp got=%b exp=1", dp_n); end
    step(8);
    n_checks++; if (anode !== 4'b0111) begin n_fail++; $display("FAIL ld_d3_anode got=%b exp=0111", anode); end
    n_checks++; if (cathode !== 7'b1001111) begin n_fail++; $display("FAIL ld_d3_cathode got=%b exp=1001111", cathode); end
  endtask

  // Entered 14 cycles into a frame; one more cycle reaches the wrap cycle.
  task automatic test_coincident();
    step(1);
    digits_in = 16'h8888;
    dp_in     = 4'b0000;
    load      = 1'b1;
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL co_pending_pre got=%b exp=0", pending); end
    step(1);
    load = 1'b0;
    n_checks++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL co_tick got=%b exp=1", frame_tick); end
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL co_pending_wrap got=%b exp=0", pending); end
    step(2);
    n_checks++; if (cathode !== 7'b0000000) begin n_fail++; $display("FAIL co_cathode got=%b exp=0000000", cathode); end
    n_checks++; if (anode !== 4'b1110) begin n_fail++; $display("FAIL co_anode got=%b exp=1110", anode); end
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL co_pending_post got=%b exp=0", pending); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_an;
    digits_in = 16'h1111;
    load      = 1'b1;
    step(1);
    load = 1'b0;
    step(3);
    digits_in = 16'h0000;
    load      = 1'b1;
    step(1);
    load = 1'b0;
    n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL b2b_pending got=%b exp=1", pending); end
    wait_tick("b2b");
    step(2);
    for (int d = 0; d < 4; d++) begin
      exp_an    = 4'b1111;
      exp_an[d] = 1'b0;
      n_checks++; if (anode !== exp_an) begin n_fail++; $display("FAIL b2b_anode_d%0d got=%b exp=%b", d, anode, exp_an); end
      n_checks++; if (cathode !== 7'b0000001) begin n_fail++; $display("FAIL b2b_cathode_d%0d got=%b exp=0000001", d, cathode); end
      if (d < 3) step(4);
    end
  endtask

  task automatic test_hex();
    logic [6:0] exp_a;
`ifdef SEG_HEX_EN
    exp_a = 7'b0001000;
`else
    exp_a = 7'b1111111;
`endif
    step(3);
    digits_in = 16'h000A;
    load      = 1'b1;
    step(1);
    load = 1'b0;
    wait_tick("hex");
    step(2);
    n_checks++; if (cathode !== exp_a) begin n_fail++; $display("FAIL hex_a_cathode got=%b exp=%b", cathode, exp_a); end
  endtask

  task automatic test_async_reset();
    digits_in = 16'h5555;
    dp_in     = 4'b1111;
    load      = 1'b1;
    step(1);
    load = 1'b0;
    n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL ar_pending_pre got=%b exp=1", pending); end
    @(negedge clk);
    #1 clk_run = 1'b0;
    #3 rst_n = 1'b0;
    #2;
    n_checks++; if (anode !== 4'b1111) begin n_fail++; $display("FAIL ar_anode got=%b exp=1111", anode); end
    n_checks++; if (cathode !== 7'b1111111) begin n_fail++; $display("FAIL ar_cathode got=%b exp=1111111", cathode); end
    n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL ar_tick got=%b exp=0", frame_tick); end
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL ar_pending got=%b exp=0", pending); end
    #10 rst_n = 1'b1;
    #2 clk_run = 1'b1;
    step(1);
    n_checks++; if (anode !== 4'b1111) begin n_fail++; $display("FAIL ar_restart_ghost got=%b exp=1111", anode); end
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL ar_restart_pending got=%b exp=0", pending); end
    step(1);
    n_checks++; if (anode !== 4'b1110) begin n_fail++; $display("FAIL ar_restart_anode got=%b exp=1110", anode); end
    n_checks++; if (cathode !== 7'b0000001) begin n_fail++; $display("FAIL ar_restart_cathode got=%b exp=0000001", cathode); end
    n_checks++; if (dp_n !== 1'b1) begin n_fail++; $display("FAIL ar_restart_dp got=%b exp=1", dp_n); end
  endtask

  initial begin
    digits_in = 16'h0000;
    dp_in     = 4'b0000;
    load      = 1'b0;
    test_reset();
    test_load_scan();
    test_coincident();
    test_back_to_back();
    test_hex();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
